// File: rtl/segment_7.sv
// Registered 4-bit digit code to seven-segment decoder.
// Output bit order is {g,f,e,d,c,b,a}. Polarity and hex-glyph support are build-time options.
module segment_7 #(
    parameter bit ACTIVE_LOW = 1'b1,  // 1: common anode, lit segment = 0
    parameter bit HEX_EN     = 1'b1   // 1: codes 10-15 show A,b,C,d,E,F; 0: blank
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Blank pattern in output polarity (all segments off)
    localparam logic [6:0] Blank = ACTIVE_LOW ? 7'b1111111 : 7'b0000000;

    logic [6:0] pat;       // active-high segment pattern
    logic [6:0] seg_next;  // pattern in output polarity

    // Decode digit code to active-high pattern; unknown codes fall to the blank default
    always_comb begin
        pat = 7'b0000000;
        case (bcd)
            4'h0:    pat = 7'b0111111;
            4'h1:    pat = 7'b0000110;
            4'h2:    pat = 7'b1011011;
            4'h3:    pat = 7'b1001111;
            4'h4:    pat = 7'b1100110;
            4'h5:    pat = 7'b1101101;
            4'h6:    pat = 7'b1111101;
            4'h7:    pat = 7'b0000111;
            4'h8:    pat = 7'b1111111;
            4'h9:    pat = 7'b1101111;
            4'hA:    pat = HEX_EN ? 7'b1110111 : 7'b0000000;
            4'hB:    pat = HEX_EN ? 7'b1111100 : 7'b0000000;
            4'hC:    pat = HEX_EN ? 7'b0111001 : 7'b0000000;
            4'hD:    pat = HEX_EN ? 7'b1011110 : 7'b0000000;
            4'hE:    pat = HEX_EN ? 7'b1111001 : 7'b0000000;
            4'hF:    pat = HEX_EN ? 7'b1110001 : 7'b0000000;
            default: pat = 7'b0000000;
        endcase
        seg_next = ACTIVE_LOW ? ~pat : pat;
    end

    // Output register: reset blanks the digit, otherwise load the decoded pattern
    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= Blank;
        end else begin
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_segment_7.sv
// Directed self-checking bench for segment_7 across all four polarity / hex-enable builds.
module tb_segment_7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] bcd = 4'd0;

    logic [6:0] seg_lo_hex;  // ACTIVE_LOW=1, HEX_EN=1
    logic [6:0] seg_hi_hex;  // ACTIVE_LOW=0, HEX_EN=1
    logic [6:0] seg_lo_bcd;  // ACTIVE_LOW=1, HEX_EN=0
    logic [6:0] seg_hi_bcd;  // ACTIVE_LOW=0, HEX_EN=0

    int n_cmp = 0;
    int n_err = 0;

    // Hand-written active-low expected patterns for codes 0..15 with hex glyphs
    localparam logic [6:0] SWEEP_AL [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    segment_7 #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b1)) u_lo_hex (
        .clk(clk), .rst(rst), .bcd(bcd), .seg(seg_lo_hex)
    );
    segment_7 #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b1)) u_hi_hex (
        .clk(clk), .rst(rst), .bcd(bcd), .seg(seg_hi_hex)
    );
    segment_7 #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b0)) u_lo_bcd (
        .clk(clk), .rst(rst), .bcd(bcd), .seg(seg_lo_bcd)
    );
    segment_7 #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b0)) u_hi_bcd (
        .clk(clk), .rst(rst), .bcd(bcd), .seg(seg_hi_bcd)
    );

    always #5 clk = ~clk;

    task automatic check_seg(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: seg=%b expected=%b", tag, got, exp);
        end
    endtask

    // al_exp is the active-low hex-build value; bcd-only builds blank when code_blank is set
    task automatic check_all(input string tag, input logic [6:0] al_exp, input bit code_blank);
        check_seg({tag, "/lo_hex"}, seg_lo_hex, al_exp);
        check_seg({tag, "/hi_hex"}, seg_hi_hex, ~al_exp);
        check_seg({tag, "/lo_bcd"}, seg_lo_bcd, code_blank ? 7'b1111111 : al_exp);
        check_seg({tag, "/hi_bcd"}, seg_hi_bcd, code_blank ? 7'b0000000 : ~al_exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [6:0] prev_exp;
    bit         prev_blank;
    logic [3:0] alt_bcd [4];
    logic [6:0] alt_exp [4];

    initial begin
        // Reset held with a non-blank code on the input
        rst = 1'b1;
        bcd = 4'd8;
        tick();
        check_all("rst_hold1", 7'b1111111, 1'b0);
        tick();
        check_all("rst_hold2", 7'b1111111, 1'b0);

        // First edge after release loads the decode of the current code
        rst = 1'b0;
        tick();
        check_all("rst_release", 7'b0000000, 1'b0);

        // Back-to-back sweep of every code; output must not move before the edge
        prev_exp   = 7'b0000000;
        prev_blank = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bcd = 4'(i);
            #1;
            check_all($sformatf("hold_%0d", i), prev_exp, prev_blank);
            tick();
            check_all($sformatf("sweep_%0d", i), SWEEP_AL[i], i >= 10);
            prev_exp   = SWEEP_AL[i];
            prev_blank = (i >= 10);
        end

        // Alternating 1,7,1,7 with reset asserted on the third cycle
        alt_bcd[0] = 4'd1; alt_exp[0] = 7'b1111001;
        alt_bcd[1] = 4'd7; alt_exp[1] = 7'b1111000;
        alt_bcd[2] = 4'd1; alt_exp[2] = 7'b1111111;
        alt_bcd[3] = 4'd7; alt_exp[3] = 7'b1111000;
        for (int i = 0; i < 4; i++) begin
            bcd = alt_bcd[i];
            rst = (i == 2);
            tick();
            check_all($sformatf("alt_%0d", i), alt_exp[i], 1'b0);
        end
        rst = 1'b0;

        // Reset with a hex code: every build must blank, not decode
        bcd = 4'd12;
        rst = 1'b1;
        tick();
        check_all("rst_hex", 7'b1111111, 1'b0);
        rst = 1'b0;
        tick();
        check_all("after_rst_hex", 7'b1000110, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/segment_7.md
# segment_7

Registered hexadecimal/BCD to seven-segment decoder. It converts a 4-bit digit code into the segment drive pattern for one common-anode (active-low) or common-cathode digit. It sits between the digit-select/counter logic and the display pins, and provides one clock of output registration for glitch-free pad drive.

## Interface
- `ACTIVE_LOW`, default 1: 1 = segment lit when its bit is 0 (common anode); 0 = lit when 1.
- `HEX_EN`, default 1: 1 = codes 10–15 show hex glyphs A,b,C,d,E,F; 0 = codes 10–15 blank the digit.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `bcd` input 4: digit code 0–15.
- `seg` output 7: segment drive, bit order {g,f,e,d,c,b,a} (`seg[0]`=a … `seg[6]`=g); registered.

## Operation
- Combinational decode of `bcd` to an active-high pattern P, then polarity applied: `seg_next = ACTIVE_LOW ? ~P : P`.
- Active-high P per code ({g..a}):
  - 0 0111111
  - 1 0000110
  - 2 1011011
  - 3 1001111
  - 4 1100110
  - 5 1101101
  - 6 1111101
  - 7 0000111
  - 8 1111111
  - 9 1101111
  - 10 1110111 (A)
  - 11 1111100 (b)
  - 12 0111001 (C)
  - 13 1011110 (d)
  - 14 1111001 (E)
  - 15 1110001 (F)
- `HEX_EN`=0: codes 10–15 give P=0000000 (blank).
- Any `bcd` bit X/Z in simulation gives the blank pattern, never X on `seg`.
- The decoder holds no state other than the output register.

## Timing
- Latency: exactly 1 clock. `seg` at edge N+1 reflects `bcd` sampled at edge N.
- Reset: when `rst`=1 at a rising edge, `seg` becomes blank (all segments off): 7'b1111111 if `ACTIVE_LOW`=1, else 7'b0000000. This takes priority over `bcd`.
- Deassertion: the first edge with `rst`=0 loads the decode of the current `bcd`.
- Reset mid-stream: blanks on the next edge, regardless of `bcd`. No partial state.
- `bcd` may change every cycle; each value appears on `seg` for exactly one cycle, in order.
- No combinational path from `bcd` to `seg`.

## Test plan
- Reset: with defaults, hold `rst`=1 and `bcd`=4'd8 for 2 cycles -> `seg`=1111111. Release `rst` -> next edge `seg`=0000000.
- Full sweep: defaults, apply `bcd` 0..15 on consecutive cycles -> `seg` follows one cycle later as 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
- Polarity: `ACTIVE_LOW`=0, `bcd`=4'd2 -> `seg`=1011011; during reset -> 0000000.
- BCD-only: `HEX_EN`=0, `bcd`=4'd9 -> 1101111 (active-high build) / 0010000 (active-low build). `bcd`=4'd10..15 -> blank.
- Latency/back-to-back: alternate `bcd` 1,7,1,7 every cycle -> `seg` alternates 1111001/1111000 lagging exactly one cycle. Assert reset on the third cycle -> blank on the following edge.
